// File: rtl/posit_encode_arbiter_if.sv
// Request/result bus for the shared posit encoder: NUM_REQ request lanes in,
// one tagged posit result out.
interface posit_encode_arbiter_if #(
  parameter int unsigned n       = 16,
  parameter int unsigned es      = 1,
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned MANT_WIDTH = n - es - 3;
  localparam int unsigned K_WIDTH    = $clog2(n - 1);
  localparam int unsigned IDX_WIDTH  = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                  req_valid_i;
  logic [NUM_REQ-1:0]                  req_ready_o;
  logic [NUM_REQ-1:0]                  req_sign_i;
  logic [NUM_REQ-1:0][K_WIDTH:0]       req_k_sgn_i;
  logic [NUM_REQ-1:0][es:0]            req_exp_i;
  logic [NUM_REQ-1:0][MANT_WIDTH:0]    req_mant_i;
  logic                                out_valid_o;
  logic                                out_ready_i;
  logic [n-1:0]                        out_result_o;
  logic [IDX_WIDTH-1:0]                out_id_o;

  modport master (
    output req_valid_i, req_sign_i, req_k_sgn_i, req_exp_i, req_mant_i, out_ready_i,
    input  req_ready_o, out_valid_o, out_result_o, out_id_o
  );

  modport slave (
    input  req_valid_i, req_sign_i, req_k_sgn_i, req_exp_i, req_mant_i, out_ready_i,
    output req_ready_o, out_valid_o, out_result_o, out_id_o
  );
endinterface

// File: rtl/posit_encode_arbiter.sv
// Round-robin arbiter sharing one combinational posit encoder between NUM_REQ
// requesters, with a one-entry tagged output register.

module posit_encoder #(
  parameter int unsigned n          = 16,
  parameter int unsigned es         = 1,
  parameter int unsigned MANT_WIDTH = n - es - 3,
  parameter int unsigned K_WIDTH    = $clog2(n - 1)
) (
  input  logic                      sign,
  input  logic signed [K_WIDTH:0]   k_sgn,
  input  logic [es:0]               exp,
  input  logic [MANT_WIDTH:0]       mant,
  output logic [n-1:0]              result
);
  localparam int unsigned SW = K_WIDTH + es + 3;
  localparam int unsigned TW = 1 + es + MANT_WIDTH;
  localparam int unsigned WV = 2 * n + TW;
  localparam logic signed [SW-1:0] KMAX_S = SW'(n - 2);
  localparam logic signed [SW-1:0] ONE_S  = SW'(1);

  logic signed [SW-1:0] scale;
  logic signed [SW-1:0] k_eff;
  logic [es-1:0]        e_eff;
  logic [SW-1:0]        run_len;
  logic [TW-1:0]        tail;
  logic [WV-1:0]        body;
  logic [n-2:0]         trunc;
  logic                 guard;
  logic                 sticky;
  logic [n-1:0]         rounded;
  logic [n-2:0]         mag;

  // exp may exceed 2^es-1, so fold it into the combined scale before splitting into regime/exponent
  assign scale   = (SW'(k_sgn) <<< es) + $signed({{(SW-es-1){1'b0}}, exp});
  assign k_eff   = scale >>> es;
  assign e_eff   = scale[es-1:0];
  assign run_len = k_eff[SW-1] ? $unsigned(-k_eff) : $unsigned(k_eff + ONE_S);
  assign tail    = {k_eff[SW-1], e_eff, mant[MANT_WIDTH-1:0]};

  // Regime run of ones (k>=0) or zeros (k<0), then terminator, exponent, fraction
  assign body    = ({tail, {(WV-TW){1'b0}}} >> run_len)
                 | (k_eff[SW-1] ? '0 : ~({WV{1'b1}} >> run_len));
  assign trunc   = body[WV-1 -: n-1];
  assign guard   = body[WV-n];
  assign sticky  = |body[WV-n-1:0];
  assign rounded = {1'b0, trunc} + {{(n-1){1'b0}}, guard & (sticky | trunc[0])};

  always_comb begin
    if (k_eff > KMAX_S)       mag = '1;
    else if (k_eff < -KMAX_S) mag = {{(n-2){1'b0}}, 1'b1};
    else if (rounded[n-1])    mag = '1;
    else                      mag = rounded[n-2:0];

    if (!mant[MANT_WIDTH]) result = '0;
    else if (sign)         result = -{1'b0, mag};
    else                   result = {1'b0, mag};
  end
endmodule

module posit_encode_arbiter #(
  parameter int unsigned n       = 16,
  parameter int unsigned es      = 1,
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  posit_encode_arbiter_if.slave  bus
);
  localparam int unsigned MANT_WIDTH = n - es - 3;
  localparam int unsigned K_WIDTH    = $clog2(n - 1);
  localparam int unsigned IDX_WIDTH  = $clog2(NUM_REQ);

  logic                      out_valid;
  logic [n-1:0]              out_result;
  logic [IDX_WIDTH-1:0]      out_id;
  logic [IDX_WIDTH-1:0]      rr_ptr;
  logic [IDX_WIDTH-1:0]      next_ptr;
  logic                      can_accept;
  logic                      any_grant;
  logic [IDX_WIDTH-1:0]      grant_idx;
  logic [NUM_REQ-1:0]        grant;
  int unsigned               cand;

  logic                      sel_sign;
  logic signed [K_WIDTH:0]   sel_k;
  logic [es:0]               sel_exp;
  logic [MANT_WIDTH:0]       sel_mant;
  logic [n-1:0]              enc_result;

  assign can_accept = ~out_valid | bus.out_ready_i;

  always_comb begin
    any_grant = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = 32'(rr_ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any_grant && bus.req_valid_i[cand[IDX_WIDTH-1:0]]) begin
        any_grant = 1'b1;
        grant_idx = cand[IDX_WIDTH-1:0];
      end
    end
    if (!can_accept || !rst_ni) any_grant = 1'b0;
    grant = any_grant ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  assign next_ptr = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

  assign sel_sign = bus.req_sign_i[grant_idx];
  assign sel_k    = bus.req_k_sgn_i[grant_idx];
  assign sel_exp  = bus.req_exp_i[grant_idx];
  assign sel_mant = bus.req_mant_i[grant_idx];

  posit_encoder #(
    .n          (n),
    .es         (es),
    .MANT_WIDTH (MANT_WIDTH),
    .K_WIDTH    (K_WIDTH)
  ) u_enc (
    .sign   (sel_sign),
    .k_sgn  (sel_k),
    .exp    (sel_exp),
    .mant   (sel_mant),
    .result (enc_result)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_id     <= '0;
      rr_ptr     <= '0;
    end else if (can_accept) begin
      if (any_grant) begin
        out_valid  <= 1'b1;
        out_result <= enc_result;
        out_id     <= grant_idx;
        rr_ptr     <= next_ptr;
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end

  assign bus.req_ready_o  = grant;
  assign bus.out_valid_o  = out_valid;
  assign bus.out_result_o = out_result;
  assign bus.out_id_o     = out_id;
endmodule

// File: tb/tb_posit_encode_arbiter.sv
// Bench for posit_encode_arbiter (n=16, es=1, 4 requesters): directed scenarios
// with a queue of expected tagged results retired against the output register.
module tb_posit_encode_arbiter;
  localparam int unsigned N  = 16;
  localparam int unsigned ES = 1;
  localparam int unsigned NR = 4;
  localparam int          NV = 15;

  typedef struct packed {
    logic        s;
    logic [4:0]  k;
    logic [1:0]  e;
    logic [12:0] m;
    logic [15:0] r;
  } vec_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] r;
  } sb_t;

  // Hand-derived posit<16,1> encodings
  vec_t tbl [NV] = '{
    '{1'b0, 5'h00, 2'd0, 13'h1000, 16'h4000},
    '{1'b0, 5'h00, 2'd1, 13'h1000, 16'h5000},
    '{1'b1, 5'h00, 2'd0, 13'h1000, 16'hC000},
    '{1'b0, 5'h00, 2'd0, 13'h0800, 16'h0000},
    '{1'b0, 5'h0F, 2'd0, 13'h1000, 16'h7FFF},
    '{1'b0, 5'h10, 2'd0, 13'h1000, 16'h0001},
    '{1'b0, 5'h01, 2'd0, 13'h1001, 16'h6000},
    '{1'b0, 5'h01, 2'd0, 13'h1003, 16'h6002},
    '{1'b0, 5'h1F, 2'd0, 13'h1000, 16'h2000},
    '{1'b0, 5'h00, 2'd0, 13'h1800, 16'h4800},
    '{1'b1, 5'h01, 2'd1, 13'h1000, 16'h9800},
    '{1'b0, 5'h0E, 2'd0, 13'h1000, 16'h7FFF},
    '{1'b0, 5'h12, 2'd0, 13'h1000, 16'h0001},
    '{1'b0, 5'h02, 2'd0, 13'h1FFF, 16'h7400},
    '{1'b0, 5'h00, 2'd2, 13'h1000, 16'h6000}
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  posit_encode_arbiter_if #(.n(N), .es(ES), .NUM_REQ(NR)) bus ();

  posit_encode_arbiter #(.n(N), .es(ES), .NUM_REQ(NR)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int vec_idx [NR];
  logic auto_adv = 1'b0;
  logic [NR-1:0] gnt_seen = '0;
  sb_t sb [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input int v);
    vec_idx[i] = v;
    bus.req_sign_i[i]  = tbl[v].s;
    bus.req_k_sgn_i[i] = tbl[v].k;
    bus.req_exp_i[i]   = tbl[v].e;
    bus.req_mant_i[i]  = tbl[v].m;
  endtask

  // One clock: retire/compare and record grants at negedge, advance stimulus just after posedge
  task automatic cycle();
    sb_t exp_e;
    sb_t got;
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (bus.out_valid_o && bus.out_ready_i) begin
        checks++;
        got = {bus.out_id_o, bus.out_result_o};
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_retire: got id=%0d res=%h, expected no result", got.id, got.r);
        end else begin
          exp_e = sb.pop_front();
          if (got !== exp_e)begin
            errors++;
            $display("FAIL sb_retire: got id=%0d res=%h, expected id=%0d res=%h",
                     got.id, got.r, exp_e.id, exp_e.r);
          end
        end
      end
      for (int i = 0; i < NR; i++)
        if (bus.req_valid_i[i] && bus.req_ready_o[i])
          sb.push_back('{id: 2'(i), r: tbl[vec_idx[i]].r});
    end
    gnt_seen = bus.req_valid_i & bus.req_ready_o;
    @(posedge clk);
    #1;
    if (auto_adv)
      for (int i = 0; i < NR; i++)
        if (gnt_seen[i]) set_req(i, (vec_idx[i] + 1) % NV);
  endtask

  task automatic test_reset();
    bus.req_valid_i = '1;
    #3;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.out_result_o !== 16'h0 || bus.out_id_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_out: got v=%b res=%h id=%0d, expected 0/0000/0",
               bus.out_valid_o, bus.out_result_o, bus.out_id_o);
    end
    checks++;
    if (bus.req_ready_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 0000", bus.req_ready_o);
    end
    bus.req_valid_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    set_req(0, 0);
    bus.req_valid_i = 4'b0001;
    #1;
    checks++;
    if (bus.req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready: got %b expected 0001", bus.req_ready_o);
    end
    cycle();
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.out_result_o !== 16'h4000 || bus.out_id_o !== 2'd0) begin
      errors++;
      $display("FAIL single_out: got v=%b res=%h id=%0d, expected 1/4000/0",
               bus.out_valid_o, bus.out_result_o, bus.out_id_o);
    end
    bus.req_valid_i = '0;
    cycle();
    checks++;
    if (bus.out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_bubble: got out_valid=%b expected 0", bus.out_valid_o);
    end
  endtask

  task automatic test_values();
    for (int v = 0; v < NV; v++) begin
      int i;
      logic [NR-1:0] oh;
      i = v % NR;
      oh = NR'(1) << i;
      set_req(i, v);
      bus.req_valid_i = oh;
      cycle();
      checks++;
      if (gnt_seen !== oh) begin
        errors++;
        $display("FAIL values_grant[%0d]: got %b expected %b", v, gnt_seen, oh);
      end
      checks++;
      if (bus.out_result_o !== tbl[v].r || bus.out_id_o !== 2'(i)) begin
        errors++;
        $display("FAIL values_enc[%0d]: got res=%h id=%0d expected res=%h id=%0d",
                 v, bus.out_result_o, bus.out_id_o, tbl[v].r, i);
      end
    end
    bus.req_valid_i = '0;
    cycle();
  endtask

  task automatic test_round_robin();
    bus.req_valid_i = 4'b1000;
    cycle();
    for (int i = 0; i < NR; i++) set_req(i, i);
    auto_adv = 1'b1;
    bus.req_valid_i = '1;
    for (int c = 0; c < 5; c++) begin
      logic [NR-1:0] eg;
      eg = NR'(1) << (c % NR);
      cycle();
      checks++;
      if (gnt_seen !== eg) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b expected %b", c, gnt_seen, eg);
      end
      checks++;
      if (bus.out_id_o !== 2'(c % NR)) begin
        errors++;
        $display("FAIL rr_id[%0d]: got %0d expected %0d", c, bus.out_id_o, c % NR);
      end
    end
    auto_adv = 1'b0;
    bus.req_valid_i = '0;
    cycle();
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    set_req(0, 9);
    set_req(1, 10);
    set_req(2, 13);
    bus.req_valid_i = 4'b0001;
    cycle();
    held = tbl[9].r;
    bus.out_ready_i = 1'b0;
    bus.req_valid_i = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks++;
      if (gnt_seen !== 4'b0000 || bus.req_ready_o !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got seen=%b ready=%b expected 0000", c, gnt_seen, bus.req_ready_o);
      end
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.out_result_o !== held || bus.out_id_o !== 2'd0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b res=%h id=%0d expected 1/%h/0",
                 c, bus.out_valid_o, bus.out_result_o, bus.out_id_o, held);
      end
    end
    bus.out_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.req_ready_o !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release_ready: got %b expected 0010", bus.req_ready_o);
    end
    cycle();
    checks++;
    if (bus.out_id_o !== 2'd1 || bus.out_result_o !== tbl[10].r) begin
      errors++;
      $display("FAIL bp_release_out: got id=%0d res=%h expected 1/%h", bus.out_id_o, bus.out_result_o, tbl[10].r);
    end
    cycle();
    checks++;
    if (gnt_seen !== 4'b0100) begin
      errors++;
      $display("FAIL bp_next_grant: got %b expected 0100", gnt_seen);
    end
    bus.req_valid_i = '0;
    cycle();
  endtask

  task automatic test_wrap();
    bus.req_valid_i = 4'b0100;
    cycle();
    set_req(3, 4);
    set_req(0, 5);
    bus.req_valid_i = 4'b1001;
    for (int c = 0; c < 3; c++) begin
      logic [NR-1:0] eg;
      eg = (c % 2 == 0) ? 4'b1000 : 4'b0001;
      cycle();
      checks++;
      if (gnt_seen !== eg) begin
        errors++;
        $display("FAIL wrap_grant[%0d]: got %b expected %b", c, gnt_seen, eg);
      end
    end
    bus.req_valid_i = '0;
    cycle();
  endtask

  task automatic test_reset_mid();
    set_req(1, 1);
    set_req(3, 2);
    bus.req_valid_i = 4'b0010;
    cycle();
    bus.out_ready_i = 1'b0;
    bus.req_valid_i = 4'b1010;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.out_result_o !== 16'h0 || bus.out_id_o !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_out: got v=%b res=%h id=%0d expected 0/0000/0",
               bus.out_valid_o, bus.out_result_o, bus.out_id_o);
    end
    checks++;
    if (bus.req_ready_o !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_ready: got %b expected 0000", bus.req_ready_o);
    end
    cycle();
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.req_ready_o !== 4'b0010) begin
      errors++;
      $display("FAIL rstmid_first_ready: got %b expected 0010", bus.req_ready_o);
    end
    cycle();
    checks++;
    if (gnt_seen !== 4'b0010 || bus.out_id_o !== 2'd1 || bus.out_result_o !== tbl[1].r) begin
      errors++;
      $display("FAIL rstmid_first_out: got seen=%b id=%0d res=%h expected 0010/1/%h",
               gnt_seen, bus.out_id_o, bus.out_result_o, tbl[1].r);
    end
    bus.req_valid_i = '0;
    cycle();
    cycle();
    checks++;
    if (sb.size() != 0 || bus.out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL drain: got pending=%0d out_valid=%b expected 0/0", sb.size(), bus.out_valid_o);
    end
  endtask

  initial begin
    bus.req_valid_i = '0;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 0);
    test_reset();
    test_single();
    test_values();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
